// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/capture stage in front of the 32-bit ripple-carry ALU.
// It accepts one command, holds the operands on the ALU inputs for
// SETTLE_CYCLES clocks, captures the result and flags into registers, and
// returns them over a valid/ready response handshake.
// Optional feature macro: ALU_ISSUE_STATS_EN adds the stat_ops/stat_ovf counters.
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_oper,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_cout,
    input  logic        alu_over,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_cout,
    output logic        rsp_over,
    output logic        rsp_err
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_ops,
    output logic [15:0] stat_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0]       OP_ADD   = 3'b010;
    localparam logic [2:0]       OP_SUB   = 3'b110;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       alu_a_q, alu_a_d;
    logic [31:0]       alu_b_q, alu_b_d;
    logic [2:0]        alu_oper_q, alu_oper_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_over_q, rsp_over_d;
    logic              rsp_err_q, rsp_err_d;
    logic              op_illegal;
    logic              rsp_fire;

    // Opcodes 011 and 101 have no ALU function and are answered with an error.
    assign op_illegal = (cmd_op == 3'b011) || (cmd_op == 3'b101);
    assign rsp_fire   = rsp_valid_q && rsp_ready;
    assign cmd_ready  = (state_q == IDLE);

    // Next-state and datapath-load decisions for the issue FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_oper_d   = alu_oper_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_over_d   = rsp_over_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d    = cmd_a;
                    alu_b_d    = cmd_b;
                    alu_oper_d = cmd_op;
                    if (op_illegal) begin
                        // Skip the settle wait; answer immediately with an error.
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b0;
                        rsp_cout_d   = 1'b0;
                        rsp_over_d   = 1'b0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    // Operands have been stable long enough for the ripple to settle.
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_cout_d   = alu_cout;
                    rsp_over_d   = alu_over;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and response registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_oper_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_over_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_oper_q   <= alu_oper_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_over_q   <= rsp_over_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_oper   = alu_oper_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_over   = rsp_over_q;
    assign rsp_err    = rsp_err_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops_q;
    logic [15:0] stat_ovf_q;
    logic        ovf_event;

    // alu_oper_q still holds the opcode of the response being handed over.
    assign ovf_event = rsp_fire && !rsp_err_q && rsp_over_q &&
                       ((alu_oper_q == OP_ADD) || (alu_oper_q == OP_SUB));

    // Count completed responses (wrapping) and signed-overflow results (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q <= '0;
            stat_ovf_q <= '0;
        end else begin
            if (rsp_fire) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end
            if (ovf_event && (stat_ovf_q != 16'hFFFF)) begin
                stat_ovf_q <= stat_ovf_q + 16'd1;
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule
